// File: rtl/wb_pkg.sv
// Shared constants and helpers for the multi-lane writeback unit.
// Latency: n/a (package: constants and pure functions only).
// Backpressure: n/a.
// Contents: default DATA_W / NUM_REGS / RD_LSB, get_rd() field extraction, popcount().
package wb_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;
  localparam int RD_LSB_DEF   = 8;
  localparam int INSTR_W      = 16;

  // Returns the instruction shifted so the destination field sits at bit 0;
  // callers size-cast to their register address width.
  function automatic logic [INSTR_W-1:0] get_rd(input logic [INSTR_W-1:0] instr,
                                                input int unsigned lsb = RD_LSB_DEF);
    return instr >> lsb;
  endfunction

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/writeback_unit_mp_if.sv
// Bundle of writeback, issue and read-port signals for writeback_unit_mp.
// Latency: n/a (wiring only).
// Backpressure: none; every request is accepted each cycle.
// Ports: master drives wb_*/iss_*/rd_addr, slave (the unit) drives rd_data/rd_busy/busy_vec/wb_count.
interface writeback_unit_mp_if #(
  parameter int NUM_LANES  = 2,
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RPORTS = 4
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic [NUM_LANES-1:0]          wb_iswb;
  logic [NUM_LANES-1:0]          wb_isld;
  logic [NUM_LANES*16-1:0]       wb_instr;
  logic [NUM_LANES*DATA_W-1:0]   wb_ldresult;
  logic [NUM_LANES*DATA_W-1:0]   wb_aluresult;
  logic [NUM_LANES-1:0]          iss_valid;
  logic [NUM_LANES*REG_AW-1:0]   iss_rd;
  logic [NUM_RPORTS*REG_AW-1:0]  rd_addr;
  logic [NUM_RPORTS*DATA_W-1:0]  rd_data;
  logic [NUM_RPORTS-1:0]         rd_busy;
  logic [NUM_REGS-1:0]           busy_vec;
  logic [31:0]                   wb_count;

  modport master (
    output wb_iswb, wb_isld, wb_instr, wb_ldresult, wb_aluresult,
    output iss_valid, iss_rd, rd_addr,
    input  rd_data, rd_busy, busy_vec, wb_count
  );

  modport slave (
    input  wb_iswb, wb_isld, wb_instr, wb_ldresult, wb_aluresult,
    input  iss_valid, iss_rd, rd_addr,
    output rd_data, rd_busy, busy_vec, wb_count
  );
endinterface

// File: rtl/wb_lane_merge.sv
// Priority merge of per-lane writes into per-register write-enable and data.
// Latency: combinational.
// Backpressure: none.
// Ports: lane_en/lane_rd/lane_data in per lane; reg_we/reg_wdata out per register.
module wb_lane_merge #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic [NUM_LANES-1:0]             lane_en,
  input  logic [NUM_LANES-1:0][REG_AW-1:0] lane_rd,
  input  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data,
  output logic [NUM_REGS-1:0]              reg_we,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  reg_wdata
);

  // Lanes are scanned oldest to youngest so the youngest (highest index)
  // writer to a register overwrites earlier ones.
  always_comb begin
    reg_we    = '0;
    reg_wdata = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_en[i] && lane_rd[i] == REG_AW'(r)) begin
          reg_we[r]    = 1'b1;
          reg_wdata[r] = lane_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/writeback_unit_mp.sv
// Multi-lane writeback: register file, bypassed read ports, busy scoreboard, writeback counter.
// Latency: writes commit at the presenting edge; reads and rd_busy are combinational with bypass.
// Backpressure: none; every lane request is accepted every cycle.
// Ports: clk, rst_n (async active-low), bus (writeback_unit_mp_if.slave).
module writeback_unit_mp
  import wb_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int NUM_RPORTS = 4,
  parameter int RD_LSB     = RD_LSB_DEF,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_unit_mp_if.slave  bus
);

  localparam int REG_AW = $clog2(NUM_REGS);

  logic [NUM_LANES-1:0][15:0]         lane_instr;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_ld;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_alu;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_data;
  logic [NUM_LANES-1:0][REG_AW-1:0]   lane_rd;
  logic [NUM_LANES-1:0][REG_AW-1:0]   iss_rd;
  logic [NUM_RPORTS-1:0][REG_AW-1:0]  raddr;
  logic [NUM_RPORTS-1:0][DATA_W-1:0]  rdata;
  logic [NUM_REGS-1:0]                merge_we;
  logic [NUM_REGS-1:0][DATA_W-1:0]    merge_wdata;
  logic [NUM_REGS-1:0]                busy_q;
  logic [NUM_REGS-1:0]                busy_nxt;
  logic [31:0]                        wb_count_q;
  logic [32:0]                        cnt_sum;
  logic [DATA_W-1:0]                  reg_file [NUM_REGS];

  assign lane_instr = bus.wb_instr;
  assign lane_ld    = bus.wb_ldresult;
  assign lane_alu   = bus.wb_aluresult;
  assign iss_rd     = bus.iss_rd;
  assign raddr      = bus.rd_addr;

  always_comb begin
    lane_data = '0;
    lane_rd   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_data[i] = bus.wb_isld[i] ? lane_ld[i] : lane_alu[i];
      lane_rd[i]   = REG_AW'(get_rd(lane_instr[i], RD_LSB));
    end
  end

  // One merge feeds both the array write and the read bypass, so a bypassed
  // read always sees exactly the value that will land in the array.
  wb_lane_merge #(
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .REG_AW    (REG_AW)
  ) u_merge (
    .lane_en   (bus.wb_iswb),
    .lane_rd   (lane_rd),
    .lane_data (lane_data),
    .reg_we    (merge_we),
    .reg_wdata (merge_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) reg_file[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (merge_we[r] && !(R0_ZERO && r == 0)) reg_file[r] <= merge_wdata[r];
      end
    end
  end

  // Issue set beats writeback clear: a fresh producer supersedes the old one.
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (merge_we[r]) busy_nxt[r] = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.iss_valid[i] && iss_rd[i] == REG_AW'(r)) busy_nxt[r] = 1'b1;
      end
      if (R0_ZERO && r == 0) busy_nxt[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      if (R0_ZERO && raddr[p] == '0) rdata[p] = '0;
      else if (merge_we[raddr[p]])   rdata[p] = merge_wdata[raddr[p]];
      else                           rdata[p] = reg_file[raddr[p]];
    end
  end

  always_comb begin
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RPORTS; p++) bus.rd_busy[p] = busy_nxt[raddr[p]];
  end

  // Dropped conflict losers and r0 writes still count: count raw requests.
  assign cnt_sum = {1'b0, wb_count_q} + {1'b0, popcount(32'(bus.wb_iswb))};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wb_count_q <= '0;
    else if (cnt_sum[32]) wb_count_q <= '1;
    else                 wb_count_q <= cnt_sum[31:0];
  end

  assign bus.rd_data  = rdata;
  assign bus.busy_vec = busy_q;
  assign bus.wb_count = wb_count_q;

endmodule
